// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port data RAM arbiter.
// Imported by the picker and the arbiter top level.
package mem_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        FREE,
        LOCK0,
        LOCK1
    } arb_state_t;

    typedef logic port_idx_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin picker.
// Returns a one-hot pick; prio breaks ties.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  port_idx_t            prio,
    output logic [NUM_PORTS-1:0] pick
);

    always_comb begin
        pick = '0;
        unique case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = prio ? 2'b10 : 2'b01;
            default: pick = '0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port data RAM between the LSU (port 0) and DMA (port 1).
// Round-robin in FREE, sticky grant while the owner holds its lock.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_PORTS-1:0]  req,
    input  logic [NUM_PORTS-1:0]  we,
    input  logic [NUM_PORTS-1:0]  lock,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0]      wdata0,
    input  logic [WIDTH-1:0]      wdata1,
    output logic [NUM_PORTS-1:0]  gnt,
    output logic [NUM_PORTS-1:0]  rvalid,
    output logic [WIDTH-1:0]      rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0]      ram_wdata,
    input  logic [WIDTH-1:0]      ram_rdata
);

    arb_state_t           st;
    arb_state_t           st_nx;
    port_idx_t            prio;
    port_idx_t            prio_nx;
    logic                 open_arb;
    logic [NUM_PORTS-1:0] pick;
    logic [NUM_PORTS-1:0] gnt_i;
    logic [NUM_PORTS-1:0] rtag;

    mem_arb_rr u_rr (
        .req  (req),
        .prio (prio),
        .pick (pick)
    );

    // A lock dropping this cycle already reopens arbitration.
    always_comb begin
        open_arb = (st == FREE)
                 | ((st == LOCK0) & ~lock[0])
                 | ((st == LOCK1) & ~lock[1]);
        gnt_i = '0;
        if (open_arb)
            gnt_i = pick;
        else if (st == LOCK0)
            gnt_i = {1'b0, req[0]};
        else
            gnt_i = {req[1], 1'b0};
    end

    assign gnt = rst_n ? gnt_i : '0;

    always_comb begin
        st_nx   = st;
        prio_nx = prio;
        if (open_arb) begin
            st_nx = FREE;
            if (st == LOCK0)
                prio_nx = 1'b1;
            else if (st == LOCK1)
                prio_nx = 1'b0;
            if (gnt_i[0]) begin
                prio_nx = 1'b1;
                if (lock[0])
                    st_nx = LOCK0;
            end else if (gnt_i[1]) begin
                prio_nx = 1'b0;
                if (lock[1])
                    st_nx = LOCK1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= FREE;
            prio <= 1'b0;
            rtag <= '0;
        end else begin
            st   <= st_nx;
            prio <= prio_nx;
            rtag <= gnt_i & ~we;
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (1'b1)
            gnt[0]: begin
                ram_addr  = addr0;
                ram_wdata = wdata0;
            end
            gnt[1]: begin
                ram_addr  = addr1;
                ram_wdata = wdata1;
            end
            default: begin
                ram_addr  = '0;
                ram_wdata = '0;
            end
        endcase
    end

    assign ram_we = |(we & gnt);
    assign rvalid = rtag;
    assign rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural sync RAM.
// Inputs change #1 after posedge; outputs are checked at negedge.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] we;
    logic [1:0] lock;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic [1:0] gnt;
    logic [1:0] rvalid;
    logic [7:0] rdata;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    logic [7:0] mem [256];
    logic       pre;
    int         ncmp;
    int         nerr;

    mem_arbiter #(.ADDR_WIDTH(8), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre) begin
            mem[8'h10] <= 8'h5A;
            mem[8'h11] <= 8'hA5;
            mem[8'h30] <= 8'h07;
            mem[8'h40] <= 8'h99;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic [1:0] r, input logic [1:0] w,
                       input logic [1:0] l);
        @(posedge clk);
        #1;
        req  = r;
        we   = w;
        lock = l;
        @(negedge clk);
    endtask

    initial begin
        ncmp = 0;
        nerr = 0;
        pre = 1'b1;
        rst_n = 1'b0;
        req = 2'b11;
        we = 2'b11;
        lock = 2'b00;
        addr0 = 8'h10;
        addr1 = 8'h11;
        wdata0 = 8'hEE;
        wdata1 = 8'hDD;
        @(negedge clk);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_we", ram_we, 1'b0);
        chk("rst_rvalid", rvalid, 2'b00);
        @(posedge clk);
        #1;
        pre = 1'b0;
        we = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        chk("c1_gnt", gnt, 2'b01);
        chk("c1_addr", ram_addr, 8'h10);
        drv(2'b11, 2'b00, 2'b00);
        chk("c2_gnt", gnt, 2'b10);
        chk("c2_addr", ram_addr, 8'h11);
        chk("c2_rv", rvalid, 2'b01);
        chk("c2_rd", rdata, 8'h5A);
        drv(2'b11, 2'b00, 2'b00);
        chk("c3_gnt", gnt, 2'b01);
        chk("c3_rv", rvalid, 2'b10);
        chk("c3_rd", rdata, 8'hA5);
        drv(2'b11, 2'b00, 2'b00);
        chk("c4_gnt", gnt, 2'b10);
        chk("c4_rv", rvalid, 2'b01);
        drv(2'b00, 2'b00, 2'b00);
        chk("c5_gnt", gnt, 2'b00);
        chk("c5_addr", ram_addr, 8'h00);
        chk("c5_rv", rvalid, 2'b10);
        chk("c5_rd", rdata, 8'hA5);

        drv(2'b01, 2'b00, 2'b00);
        chk("sr_gnt", gnt, 2'b01);
        chk("sr_rv0", rvalid, 2'b00);
        drv(2'b00, 2'b00, 2'b00);
        chk("sr_rv", rvalid, 2'b01);
        chk("sr_rd", rdata, 8'h5A);

        addr1 = 8'h20;
        wdata1 = 8'hC3;
        drv(2'b10, 2'b10, 2'b00);
        chk("wr_gnt", gnt, 2'b10);
        chk("wr_we", ram_we, 1'b1);
        chk("wr_addr", ram_addr, 8'h20);
        chk("wr_data", ram_wdata, 8'hC3);
        addr0 = 8'h20;
        drv(2'b01, 2'b00, 2'b00);
        chk("rd_gnt", gnt, 2'b01);
        chk("rd_we", ram_we, 1'b0);
        chk("wr_norv", rvalid, 2'b00);
        drv(2'b00, 2'b00, 2'b00);
        chk("wtr_rv", rvalid, 2'b01);
        chk("wtr_rd", rdata, 8'hC3);

        addr0 = 8'h40;
        addr1 = 8'h30;
        drv(2'b11, 2'b00, 2'b10);
        chk("lk1_gnt", gnt, 2'b10);
        wdata1 = 8'h08;
        drv(2'b11, 2'b10, 2'b10);
        chk("lk2_gnt", gnt, 2'b10);
        chk("lk2_we", ram_we, 1'b1);
        chk("lk2_rv", rvalid, 2'b10);
        chk("lk2_rd", rdata, 8'h07);
        drv(2'b01, 2'b00, 2'b10);
        chk("lk3_gnt", gnt, 2'b00);
        chk("lk3_we", ram_we, 1'b0);
        drv(2'b01, 2'b00, 2'b00);
        chk("ul_gnt", gnt, 2'b01);
        chk("ul_addr", ram_addr, 8'h40);
        drv(2'b10, 2'b00, 2'b00);
        chk("ul_rv", rvalid, 2'b01);
        chk("ul_rd", rdata, 8'h99);
        chk("m30_gnt", gnt, 2'b10);
        drv(2'b00, 2'b00, 2'b00);
        chk("m30_rv", rvalid, 2'b10);
        chk("m30_rd", rdata, 8'h08);

        addr0 = 8'h10;
        drv(2'b01, 2'b00, 2'b00);
        chk("mr_gnt", gnt, 2'b01);
        @(posedge clk);
        #1;
        req = 2'b00;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_rv", rvalid, 2'b00);
        chk("mr_st", dut.st, FREE);
        chk("mr_prio", dut.prio, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_rv2", rvalid, 2'b00);
        drv(2'b11, 2'b00, 2'b00);
        chk("mr_gnt2", gnt, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
